// File: rtl/spi_slave_rx_sync.sv
// spi_slave_rx_sync
//   Receive-only SPI slave that runs entirely on the system clock. It
//   oversamples sclk, cs and mosi through synchronizer chains, finds sclk
//   rising edges, shifts in one DATA_WIDTH-bit frame per cs-low window,
//   presents the word on dout and pulses done. A cs deassertion before the
//   frame completes is reported with a one-cycle frame_error pulse.
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-low reset
//   sclk         SPI clock from master (asynchronous, idle low)
//   cs           chip select, active-low (asynchronous)
//   mosi         serial data, valid at sclk rising edge
//   dout         last complete received word, held until the next done
//   done         one-cycle pulse when dout updates
//   busy         high while a frame is being shifted in (SHIFT state)
//   frame_error  one-cycle pulse when cs rises mid-frame
//   state_dbg    current FSM state (IDLE=0, SHIFT=1, WAIT_CS=2)
//
// Handshake: done and frame_error are single-cycle strobes with no ready
// back-pressure; dout is valid from the cycle done is high until the next
// done.

module spi_slave_rx_sync #(
  parameter int DATA_WIDTH  = 12,
  parameter int SYNC_STAGES = 2,
  parameter bit LSB_FIRST   = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  done,
  output logic                  busy,
  output logic                  frame_error,
  output logic [1:0]            state_dbg
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int FW = $clog2(SYNC_STAGES + 3);
  localparam logic [CW-1:0] FULL      = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] LAST      = CW'(DATA_WIDTH - 1);
  localparam logic [FW-1:0] FLUSH_LEN = FW'(SYNC_STAGES + 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } state_t;

  // Synchronizer chains plus history flops
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_hist, cs_hist;

  // Registered edge strobes; mosi_q travels alongside sclk_rise_q so the
  // sampled bit stays aligned with its clock edge.
  logic sclk_rise_q, cs_fall_q, cs_rise_q, cs_high_q, mosi_q;

  // After reset the cs chain holds 1 while the real level propagates. A
  // fall seen before the chain has flushed and cs has been observed high
  // would start a bogus partial frame, so cs_fall is only honoured once
  // armed.
  logic [FW-1:0] flush_cnt;
  logic          armed;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d, shreg_shifted;
  logic [DATA_WIDTH-1:0] dout_d;
  logic                  done_d, err_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sclk_sync   <= '0;
      cs_sync     <= '1;
      mosi_sync   <= '0;
      sclk_hist   <= 1'b0;
      cs_hist     <= 1'b1;
      sclk_rise_q <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_high_q   <= 1'b1;
      mosi_q      <= 1'b0;
      flush_cnt   <= '0;
      armed       <= 1'b0;
    end else begin
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync     <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_hist   <= sclk_sync[SYNC_STAGES-1];
      cs_hist     <= cs_sync[SYNC_STAGES-1];
      sclk_rise_q <= sclk_sync[SYNC_STAGES-1] & ~sclk_hist;
      cs_fall_q   <= ~cs_sync[SYNC_STAGES-1] & cs_hist;
      cs_rise_q   <= cs_sync[SYNC_STAGES-1] & ~cs_hist;
      cs_high_q   <= cs_sync[SYNC_STAGES-1];
      mosi_q      <= mosi_sync[SYNC_STAGES-1];
      if (flush_cnt != FLUSH_LEN) flush_cnt <= flush_cnt + 1'b1;
      if (flush_cnt == FLUSH_LEN && cs_high_q) armed <= 1'b1;
    end
  end

  always_comb begin
    if (LSB_FIRST) shreg_shifted = {mosi_q, shreg_q[DATA_WIDTH-1:1]};
    else           shreg_shifted = {shreg_q[DATA_WIDTH-2:0], mosi_q};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      dout        <= '0;
      done        <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      dout        <= dout_d;
      done        <= done_d;
      frame_error <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    dout_d  = dout;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall_q && armed) begin
          cnt_d   = '0;
          shreg_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == FULL) begin
          // Word completed on the previous edge. If cs already went high
          // (possibly together with the final sclk edge) skip WAIT_CS.
          dout_d  = shreg_q;
          done_d  = 1'b1;
          state_d = cs_high_q ? IDLE : WAIT_CS;
        end else begin
          if (sclk_rise_q) begin
            shreg_d = shreg_shifted;
            cnt_d   = cnt_q + 1'b1;
          end
          // The sclk edge wins a tie: a completing final bit is not an error.
          if (cs_rise_q && !(sclk_rise_q && cnt_q == LAST)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_CS: begin
        if (cs_rise_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == SHIFT);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_slave_rx_sync.sv
module tb_spi_slave_rx_sync;

  localparam int W   = 12;
  localparam int S   = 2;
  localparam bit LSB = 1'b1;

  // ---------------- clock / reset / DUT ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic sclk  = 1'b0;
  logic cs    = 1'b1;
  logic mosi  = 1'b0;
  logic [W-1:0] dout;
  logic         done, busy, frame_error;
  logic [1:0]   state_dbg;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  spi_slave_rx_sync #(
    .DATA_WIDTH (W),
    .SYNC_STAGES(S),
    .LSB_FIRST  (LSB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .sclk       (sclk),
    .cs         (cs),
    .mosi       (mosi),
    .dout       (dout),
    .done       (done),
    .busy       (busy),
    .frame_error(frame_error),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_last = '0;
  int exp_done = 0, exp_err = 0, obs_done = 0, obs_err = 0;
  int last_rise_cyc = 0, done_cyc = 0;
  bit sent_bits[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: the first W bits of a cs-low window form the word, ordered
  // by bit position according to LSB.
  function automatic logic [W-1:0] assemble_word();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (LSB) w[i] = sent_bits[i];
      else     w[W-1-i] = sent_bits[i];
    end
    return w;
  endfunction

  // Output monitor, sampled mid-cycle
  always @(negedge clock) begin
    if (reset === 1'b1 && done === 1'b1) begin
      obs_done++;
      done_cyc = cyc;
      if (exp_q.size() == 0) check("done_unexpected", 1, 0);
      else                   check("dout_at_done", dout, exp_q.pop_front());
      check("busy_at_done", busy, 0);
    end
    if (reset === 1'b1 && frame_error === 1'b1) obs_err++;
  end

  // ---------------- driver ----------------
  // nbits sclk pulses inside one cs-low window; bits past W are random.
  // rst_after > 0 pulses reset after that many bits while cs stays low.
  task automatic send_frame(input logic [W-1:0] word, input int nbits,
                            input int half, input int rst_after);
    logic b;
    sent_bits.delete();
    @(negedge clock);
    cs = 1'b0;
    repeat (half) @(negedge clock);
    for (int i = 0; i < nbits; i++) begin
      b = (i < W) ? word[i] : 1'($urandom_range(0, 1));
      mosi = b;
      sent_bits.push_back(b);
      if (sent_bits.size() == W && rst_after == 0) begin
        exp_q.push_back(assemble_word());
        exp_done++;
        model_last = assemble_word();
      end
      repeat (half) @(negedge clock);
      sclk = 1'b1;
      last_rise_cyc = cyc + 1;
      repeat (half) @(negedge clock);
      sclk = 1'b0;
      if (rst_after == 0 && i == 1) check("busy_mid_frame", busy, 1);
      if (rst_after != 0 && i + 1 == rst_after) begin
        reset = 1'b0;
        model_last = '0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
      end
    end
    if (rst_after == 0 && nbits < W) exp_err++;
    repeat (half) @(negedge clock);
    cs   = 1'b1;
    mosi = 1'b0;
    repeat (half + S + 8) @(negedge clock);
    check("done_count", obs_done, exp_done);
    check("error_count", obs_err, exp_err);
    check("dout_hold", dout, model_last);
    check("busy_after", busy, 0);
    check("exp_q_drained", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int half, nb;
    logic [W-1:0] w;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Reset then idle
    repeat (50) begin
      @(negedge clock);
      check("idle_outputs", {dout, done, busy, frame_error}, 0);
    end

    // Single frame with latency check
    send_frame(12'hA5C, W, 8, 0);
    check("done_latency", done_cyc - last_rise_cyc, S + 2);

    // Back-to-back
    send_frame(12'h001, W, 8, 0);
    repeat (4 * 16) @(negedge clock);
    send_frame(12'hFFF, W, 8, 0);

    // Aborted frame, then recovery
    send_frame(12'h2B5, 5, 8, 0);
    send_frame(12'h3C3, W, 8, 0);

    // Overlong frame
    send_frame(12'h800, 14, 8, 0);

    // Reset mid-frame, released while cs still low
    send_frame(12'h7E1, W, 8, 6);
    send_frame(12'h123, W, 8, 0);

    // Randomized frames
    for (int k = 0; k < 24; k++) begin
      w    = W'($urandom);
      half = $urandom_range(S + 1, 8);
      case ($urandom_range(0, 3))
        0:       nb = $urandom_range(1, W - 1);
        1:       nb = $urandom_range(W + 1, W + 3);
        default: nb = W;
      endcase
      send_frame(w, nb, half, 0);
    end

    check("final_done_count", obs_done, exp_done);
    check("final_error_count", obs_err, exp_err);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
